shift_seq_rotator: RTL and testbench

SHIFT_SEQ_ROTATOR -- requirements
Module: shift_seq_rotator

---
 rtl/shift_seq_rotator.sv | 136 +++++++++++++
 tb/tb_shift_seq_rotator.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/shift_seq_rotator.sv
// shift_seq_rotator
//   Sequential barrel-shift replacement: moves the operand one bit position
//   per clock, so an operation with shift amount k takes k RUN cycles.
//   The result is published on Y only when the operation completes.
//
// Ports
//   Clock  in   rising-edge clock for all state
//   Resetn in   synchronous active-low reset
//   A      in   operand, captured when a start is accepted
//   Shift  in   shift amount 0..WIDTH-1, captured when a start is accepted
//   Mode   in   00 rotate right, 01 rotate left, 10 logical right,
//               11 arithmetic right
//   start  in   request a new operation (honoured only in IDLE)
//   busy   out  high while in RUN or DONE
//   done   out  one-cycle pulse: Y has just been loaded with a new result
//   Y      out  registered result, held between operations
module shift_seq_rotator #(
   parameter int WIDTH = 8,
   parameter int SW    = $clog2(WIDTH)
) (
   input  logic             Clock,
   input  logic             Resetn,
   input  logic [WIDTH-1:0] A,
   input  logic [SW-1:0]    Shift,
   input  logic [1:0]       Mode,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] Y
);

   localparam logic [1:0] M_ROR = 2'b00;
   localparam logic [1:0] M_ROL = 2'b01;
   localparam logic [1:0] M_LSR = 2'b10;
   localparam logic [1:0] M_ASR = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             state_reg, state_next;
   logic [WIDTH-1:0]   work_reg,  work_next;
   logic [SW-1:0]      count_reg, count_next;
   logic [1:0]         mode_reg,  mode_next;
   logic [WIDTH-1:0]   y_reg,     y_next;

   // One-position moves of the work register, one vector per mode.
   logic [WIDTH-1:0]   ror_w, rol_w, lsr_w, asr_w, step_w;

   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      assign ror_w[gi] = work_reg[(gi + 1) % WIDTH];
      assign rol_w[gi] = work_reg[(gi + WIDTH - 1) % WIDTH];
      if (gi == WIDTH - 1) begin : g_msb
         // MSB fill is the only difference between the two right shifts.
         assign lsr_w[gi] = 1'b0;
         assign asr_w[gi] = work_reg[WIDTH-1];
      end else begin : g_low
         assign lsr_w[gi] = work_reg[gi + 1];
         assign asr_w[gi] = work_reg[gi + 1];
      end
   end

   always_comb begin
      step_w = ror_w;
      case (mode_reg)
         M_ROR:   step_w = ror_w;
         M_ROL:   step_w = rol_w;
         M_LSR:   step_w = lsr_w;
         M_ASR:   step_w = asr_w;
         default: step_w = ror_w;
      endcase
   end

   always_comb begin
      state_next = state_reg;
      work_next  = work_reg;
      count_next = count_reg;
      mode_next  = mode_reg;
      y_next     = y_reg;
      case (state_reg)
         S_IDLE: begin
            if (start) begin
               work_next  = A;
               count_next = Shift;
               mode_next  = Mode;
               if (Shift == '0) begin
                  // Nothing to shift: publish the operand straight away.
                  y_next     = A;
                  state_next = S_DONE;
               end else begin
                  state_next = S_RUN;
               end
            end
         end
         S_RUN: begin
            work_next  = step_w;
            count_next = count_reg - 1'b1;
            if (count_reg == SW'(1)) begin
               // Last step: Y takes the freshly shifted value, never an
               // intermediate one.
               y_next     = step_w;
               state_next = S_DONE;
            end
         end
         S_DONE: begin
            state_next = S_IDLE;
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge Clock) begin
      if (!Resetn) begin
         state_reg <= S_IDLE;
         work_reg  <= '0;
         count_reg <= '0;
         mode_reg  <= '0;
         y_reg     <= '0;
      end else begin
         state_reg <= state_next;
         work_reg  <= work_next;
         count_reg <= count_next;
         mode_reg  <= mode_next;
         y_reg     <= y_next;
      end
   end

   assign busy = (state_reg != S_IDLE);
   assign done = (state_reg == S_DONE);
   assign Y    = y_reg;

endmodule

// File: tb/tb_shift_seq_rotator.sv
// Self-checking bench for shift_seq_rotator (WIDTH=8).
// A timeline model predicts busy/done/Y after every rising edge; one
// process compares the DUT against it on every falling edge. Directed
// operations additionally pin results and latency to literal values.
module tb_shift_seq_rotator;

   localparam int W  = 8;
   localparam int SW = 3;

   logic          Clock = 1'b0;
   logic          Resetn = 1'b0;
   logic [W-1:0]  A = '0;
   logic [SW-1:0] Shift = '0;
   logic [1:0]    Mode = '0;
   logic          start = 1'b0;
   logic          busy, done;
   logic [W-1:0]  Y;

   int tests = 0;
   int fails = 0;

   shift_seq_rotator #(.WIDTH(W)) dut (
      .Clock (Clock),
      .Resetn(Resetn),
      .A     (A),
      .Shift (Shift),
      .Mode  (Mode),
      .start (start),
      .busy  (busy),
      .done  (done),
      .Y     (Y)
   );

   always #5 Clock = ~Clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Whole-operation result from plain arithmetic on the operand.
   function automatic logic [W-1:0] ref_op(input logic [W-1:0] a, input logic [1:0] mode, input int k);
      logic [2*W-1:0]      d;
      logic signed [W-1:0] s;
      d = {a, a};
      s = a;
      case (mode)
         2'b00:   begin d = d >> k; return d[W-1:0]; end
         2'b01:   begin d = d << k; return d[2*W-1:W]; end
         2'b10:   return a >> k;
         default: return W'(s >>> k);
      endcase
   endfunction

   // Timeline model: an accepted op at edge n with amount k completes at
   // edge n+k and the block is free again from edge n+k+1.
   int           cyc = 0;
   bit           active = 0;
   int           done_edge = 0;
   logic [W-1:0] pend_y = '0;
   logic         exp_busy = 0, exp_done = 0;
   logic [W-1:0] exp_y = '0;
   bit           chk_en = 0;

   always @(posedge Clock) begin
      cyc++;
      if (!Resetn) begin
         active   = 0;
         exp_y    = '0;
         exp_done = 0;
         exp_busy = 0;
      end else begin
         exp_done = 0;
         if (active) begin
            if (cyc == done_edge) begin
               exp_y    = pend_y;
               exp_done = 1;
            end else if (cyc == done_edge + 1) begin
               active = 0;
            end
         end else if (start) begin
            active    = 1;
            done_edge = cyc + int'(Shift);
            pend_y    = ref_op(A, Mode, int'(Shift));
            if (Shift == '0) begin
               exp_y    = pend_y;
               exp_done = 1;
            end
         end
         exp_busy = active;
      end
      chk_en = 1;
   end

   always @(negedge Clock) begin
      if (chk_en) begin
         check("busy", 32'(busy), 32'(exp_busy));
         check("done", 32'(done), 32'(exp_done));
         check("Y",    32'(Y),    32'(exp_y));
      end
   end

   // Directed op with literal expectations; optionally disturbs the inputs
   // mid-run to show they are ignored.
   task automatic run_op(input logic [W-1:0] a, input logic [1:0] m, input logic [SW-1:0] k,
                         input logic [W-1:0] lit, input bit disturb);
      int lat;
      @(negedge Clock);
      A = a; Mode = m; Shift = k; start = 1'b1;
      @(negedge Clock);
      start = 1'b0;
      check("busy_after_accept", 32'(busy), 32'd1);
      lat = 0;
      while (!done && lat < 40) begin
         @(negedge Clock);
         lat++;
         if (disturb && lat == 2) begin
            start = 1'b1; A = ~a; Mode = ~m; Shift = ~k;
         end else if (disturb && lat == 3) begin
            start = 1'b0;
         end
      end
      check("latency", 32'(lat), 32'(k));
      check("literal_Y", 32'(Y), 32'(lit));
      @(negedge Clock);
      check("idle_after_done", 32'(busy), 32'd0);
   endtask

   initial begin
      int seen;
      repeat (3) @(negedge Clock);
      Resetn = 1'b1;

      run_op(8'h96, 2'b00, 3'd3, 8'hD2, 0);
      run_op(8'h96, 2'b01, 3'd1, 8'h2D, 0);
      run_op(8'h96, 2'b10, 3'd4, 8'h09, 0);
      run_op(8'h96, 2'b11, 3'd2, 8'hE5, 0);
      run_op(8'h96, 2'b10, 3'd0, 8'h96, 0);
      run_op(8'h81, 2'b00, 3'd7, 8'h03, 1);

      // Reset in the middle of a 5-step run: op abandoned, no done pulse.
      @(negedge Clock);
      A = 8'h5A; Mode = 2'b01; Shift = 3'd5; start = 1'b1;
      @(negedge Clock);
      start = 1'b0;
      @(negedge Clock);
      Resetn = 1'b0;
      @(negedge Clock);
      Resetn = 1'b1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_Y",    32'(Y),    32'd0);
      seen = 0;
      repeat (8) begin
         @(negedge Clock);
         if (done) seen++;
      end
      check("no_done_after_rst", 32'(seen), 32'd0);
      run_op(8'h96, 2'b00, 3'd3, 8'hD2, 0);

      // Randomised traffic: free-running inputs, occasional resets.
      for (int i = 0; i < 2000; i++) begin
         @(negedge Clock);
         A      = W'($urandom);
         Shift  = SW'($urandom);
         Mode   = 2'($urandom);
         start  = ($urandom_range(0, 9) < 4);
         Resetn = ($urandom_range(0, 99) != 0);
      end
      @(negedge Clock);
      Resetn = 1'b1;
      start  = 1'b0;
      repeat (12) @(negedge Clock);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
